// File: rtl/serial_shift_receiver.sv
// Deserializer for the 4-wire 595-style shift protocol. Every serial input is
// synchronized and edge-detected in the clk domain; nothing is clocked by ser_clk.
module serial_shift_receiver #(
    parameter int WIDTH       = 64,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_async_n,
    input  logic             ser_clk,
    input  logic             ser_do,
    input  logic             ser_pen,
    input  logic             ser_clr_n,
    output logic [WIDTH-1:0] data_out,
    output logic             frame_valid,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       bit_count,
    output logic             len_err
);

    logic [SYNC_STAGES-1:0] clk_sync, do_sync, pen_sync, clr_sync;
    logic                   clk_hist, pen_hist;
    logic                   clk_s, do_s, pen_s, clr_s;
    logic                   clk_rise, pen_rise;
    logic [WIDTH-1:0]       sreg, sreg_nxt;
    logic [7:0]             cnt_nxt;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign do_s     = do_sync[SYNC_STAGES-1];
    assign pen_s    = pen_sync[SYNC_STAGES-1];
    assign clr_s    = clr_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_hist;
    assign pen_rise = pen_s & ~pen_hist;

    // Equal-depth chains keep ser_do aligned with ser_clk after synchronization.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            clk_sync <= '0;
            do_sync  <= '0;
            pen_sync <= '0;
            clr_sync <= '0;
            clk_hist <= 1'b0;
            pen_hist <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge input.
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
            do_sync  <= {do_sync[SYNC_STAGES-2:0], ser_do};
            pen_sync <= {pen_sync[SYNC_STAGES-2:0], ser_pen};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], ser_clr_n};
            clk_hist <= clk_s;
            pen_hist <= pen_s;
        end
    end

    // Clear dominates a shift; a latch in the same cycle sees this next state.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        sreg_nxt = sreg;
        cnt_nxt  = bit_count;
        if (!clr_s) begin
            sreg_nxt = '0;
            cnt_nxt  = 8'd0;
        end else if (clk_rise) begin
            sreg_nxt = {sreg[WIDTH-2:0], do_s};
            cnt_nxt  = (bit_count == 8'hFF) ? 8'hFF : bit_count + 8'd1;
        end
    end

    // bit_count doubles as state: 0 idle, 1..WIDTH shifting, above WIDTH overrun.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            sreg        <= '0;
            bit_count   <= 8'd0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            len_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sreg        <= sreg_nxt;
            bit_count   <= cnt_nxt;
            if (pen_rise) begin
                data_out    <= sreg_nxt;
                len_err     <= (int'(cnt_nxt) != WIDTH);
                frame_count <= frame_count + CNT_W'(1);
                frame_valid <= 1'b1;
                bit_count   <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_serial_shift_receiver.sv
// Self-checking bench for serial_shift_receiver: directed scenarios plus random
// frames, compared against a bit-history reference model.
module tb_serial_shift_receiver;

    localparam int WIDTH = 64;
    localparam int SYNC  = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_async_n = 1'b0;
    logic             ser_clk = 1'b0, ser_do = 1'b0, ser_pen = 1'b0, ser_clr_n = 1'b1;
    logic [WIDTH-1:0] data_out;
    logic             frame_valid;
    logic [CNT_W-1:0] frame_count;
    logic [7:0]       bit_count;
    logic             len_err;

    serial_shift_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_async_n(rst_async_n), .ser_clk(ser_clk), .ser_do(ser_do),
        .ser_pen(ser_pen), .ser_clr_n(ser_clr_n), .data_out(data_out),
        .frame_valid(frame_valid), .frame_count(frame_count), .bit_count(bit_count),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_cycles = 0;

    always @(negedge clk) if (frame_valid) fv_cycles++;

    // Reference model: bits held since the last clear/reset, and bits since the last latch/clear.
    bit               hist[$];
    int               since_latch = 0;
    logic [WIDTH-1:0] exp_data = '0;
    logic             exp_len = 1'b0;
    int               exp_fc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [WIDTH-1:0] model_word();
        logic [WIDTH-1:0] w = '0;
        for (int k = 0; k < hist.size(); k++) w[k] = hist[hist.size()-1-k];
        return w;
    endfunction

    function automatic logic [63:0] model_count();
        return 64'((since_latch > 255) ? 255 : since_latch);
    endfunction

    task automatic model_push(input bit b);
        hist.push_back(b);
        if (hist.size() > WIDTH) void'(hist.pop_front());
        since_latch++;
    endtask

    task automatic model_latch();
        exp_data    = model_word();
        exp_len     = (since_latch != WIDTH);
        exp_fc      = (exp_fc + 1) % (1 << CNT_W);
        since_latch = 0;
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        ser_do = b;
        wait_cycles(2);
        ser_clk = 1'b1;
        wait_cycles(4);
        ser_clk = 1'b0;
        wait_cycles(4);
        model_push(b);
    endtask

    task automatic send_word(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic check_frame(input string tag, input int fv_before);
        check({tag, ".data"}, 64'(data_out), 64'(exp_data));
        check({tag, ".len_err"}, 64'(len_err), 64'(exp_len));
        check({tag, ".frame_count"}, 64'(frame_count), 64'(exp_fc));
        check({tag, ".bit_count"}, 64'(bit_count), model_count());
        check({tag, ".fv_cycles"}, 64'(fv_cycles - fv_before), 64'd1);
        check({tag, ".fv_low"}, 64'(frame_valid), 64'd0);
    endtask

    task automatic pulse_pen(input string tag);
        int fv0;
        fv0 = fv_cycles;
        @(negedge clk);
        ser_pen = 1'b1;
        wait_cycles(4);
        ser_pen = 1'b0;
        wait_cycles(4);
        model_latch();
        check_frame(tag, fv0);
    endtask

    initial begin
        logic [63:0] w;
        int          n, lat, fv0;

        wait_cycles(3);
        check("reset.data", 64'(data_out), 64'd0);
        check("reset.fc", 64'(frame_count), 64'd0);
        check("reset.flags", {61'd0, frame_valid, len_err, |bit_count}, 64'd0);
        rst_async_n = 1'b1;
        wait_cycles(4);

        send_word(64'hDEADBEEF_01234567, 64);
        check("full.bit_count", 64'(bit_count), model_count());
        pulse_pen("full");
        check("full.literal", 64'(data_out), 64'hDEADBEEF_01234567);

        send_word(64'(32'h0ABC_DEF1) << 28 | 64'h0123_4567, 60);
        pulse_pen("short60");
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 64);
        pulse_pen("ones");

        send_word(64'h1234_5678, 32);
        @(negedge clk);
        ser_clr_n = 1'b0;
        wait_cycles(2);
        check("clear.mid_data", 64'(data_out), 64'(exp_data));
        wait_cycles(2);
        ser_clr_n = 1'b1;
        wait_cycles(4);
        hist.delete();
        since_latch = 0;
        check("clear.bit_count", 64'(bit_count), 64'd0);
        check("clear.data_kept", 64'(data_out), 64'(exp_data));
        send_word(64'h5555_5555_5555_5555, 64);
        pulse_pen("after_clear");

        for (int i = 0; i < 70; i++) send_bit(1'(i % 2));
        pulse_pen("over70");
        for (int i = 0; i < 300; i++) send_bit(1'($urandom_range(0, 1)));
        check("sat.bit_count", 64'(bit_count), 64'd255);
        pulse_pen("sat_latch");

        // 64th bit rises together with ser_pen.
        w = {$urandom, $urandom};
        send_word(w >> 1, 63);
        @(negedge clk);
        ser_do = w[0];
        wait_cycles(2);
        fv0 = fv_cycles;
        ser_clk = 1'b1;
        ser_pen = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (frame_valid && lat == 0) lat = i;
        end
        ser_clk = 1'b0;
        ser_pen = 1'b0;
        wait_cycles(4);
        model_push(w[0]);
        model_latch();
        check("simul.latency", 64'(lat), 64'(SYNC + 1));
        check_frame("simul", fv0);
        check("simul.literal", 64'(data_out), w);

        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(WIDTH - 6, WIDTH + 6);
            for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
            pulse_pen($sformatf("rand%0d", f));
        end

        send_word(64'hCAFE_F00D, 20);
        @(negedge clk);
        #2 rst_async_n = 1'b0;
        #1;
        check("async_rst.data", 64'(data_out), 64'd0);
        check("async_rst.fc", 64'(frame_count), 64'd0);
        check("async_rst.flags", {61'd0, frame_valid, len_err, |bit_count}, 64'd0);
        hist.delete();
        since_latch = 0;
        exp_fc = 0;
        wait_cycles(2);
        rst_async_n = 1'b1;
        wait_cycles(4);
        send_word(64'h0F1E_2D3C_4B5A_6978, 64);
        pulse_pen("post_reset");
        check("post_reset.literal", 64'(data_out), 64'h0F1E_2D3C_4B5A_6978);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
